player_input_ctrl: RTL



---
 rtl/player_input_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/player_input_ctrl.sv
// Player-input front end: merges PS/2 keyboard and joystick words into
// per-player control words, shapes coin pulses, applies per-button
// autofire and provides a toggle-mode (or level) pause request.
module player_input_ctrl #(
    parameter int NUM_PLAYERS   = 2,
    parameter int NUM_BUTTONS   = 3,
    parameter int COIN_PULSE    = 16,
    parameter int AUTOFIRE_HALF = 833333,
    parameter int PAUSE_TOGGLE  = 1
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [10:0]                             ps2_key,
    input  logic [NUM_PLAYERS*(NUM_BUTTONS+7)-1:0]  joystick,
    input  logic [NUM_BUTTONS-1:0]                  autofire_en,
    output logic [NUM_PLAYERS*(NUM_BUTTONS+6)-1:0]  player,
    output logic                                    pause
);

    // Joystick word layout: [0]R [1]L [2]D [3]U [4+:NB] buttons, start, coin, pause.
    localparam int JW      = NUM_BUTTONS + 7;
    // Output word layout: [0]U [1]D [2]L [3]R [4+:NB] buttons, start, coin.
    localparam int OW      = NUM_BUTTONS + 6;
    localparam int START_B = NUM_BUTTONS + 4;
    localparam int COIN_B  = NUM_BUTTONS + 5;
    localparam int PAUSE_B = NUM_BUTTONS + 6;
    localparam int CW      = $clog2(COIN_PULSE + 1);
    localparam int AW      = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;

    // The extended-code flag carries no meaning for the mapped keys.
    logic unused_ext;
    assign unused_ext = ps2_key[8];

    // ------------------------------------------------------------------
    // PS/2 decode
    // ------------------------------------------------------------------
    logic ps2_toggle_q;
    logic ps2_event;
    logic dec_hit;
    int   dec_p;
    int   dec_bit;

    assign ps2_event = ps2_key[10] ^ ps2_toggle_q;

    // Map the scancode onto a (player, joystick-layout bit) pair.
    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        dec_hit = 1'b1;
        dec_p   = 0;
        dec_bit = 0;
        case (ps2_key[7:0])
            8'h74: dec_bit = 0;
            8'h6B: dec_bit = 1;
            8'h72: dec_bit = 2;
            8'h75: dec_bit = 3;
            8'h14: dec_bit = 4;
            8'h11: begin dec_bit = 5; dec_hit = (NUM_BUTTONS > 1); end
            8'h29: begin dec_bit = 6; dec_hit = (NUM_BUTTONS > 2); end
            8'h16: dec_bit = START_B;
            8'h2E: dec_bit = COIN_B;
            8'h4D: dec_bit = PAUSE_B;
            8'h34: begin dec_p = 1; dec_bit = 0; end
            8'h23: begin dec_p = 1; dec_bit = 1; end
            8'h2B: begin dec_p = 1; dec_bit = 2; end
            8'h2D: begin dec_p = 1; dec_bit = 3; end
            8'h1C: begin dec_p = 1; dec_bit = 4; end
            8'h1B: begin dec_p = 1; dec_bit = 5; dec_hit = (NUM_BUTTONS > 1); end
            8'h15: begin dec_p = 1; dec_bit = 6; dec_hit = (NUM_BUTTONS > 2); end
            8'h1E: begin dec_p = 1; dec_bit = START_B; end
            8'h36: begin dec_p = 1; dec_bit = COIN_B; end
            default: dec_hit = 1'b0;
        endcase
        if (dec_p >= NUM_PLAYERS) begin
            dec_hit = 1'b0;
        end
    end

    logic [JW-1:0] key_q [NUM_PLAYERS];

    // Key state registers; toggle history is preloaded in reset so release
    // never looks like a PS/2 event.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        ps2_toggle_q <= ps2_key[10];
        if (reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                key_q[p] <= '0;
            end
        end else if (ps2_event && dec_hit) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                for (int b = 0; b < JW; b++) begin
                    if (dec_p == p && dec_bit == b) begin
                        key_q[p][b] <= ps2_key[9];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Merge
    // ------------------------------------------------------------------
    logic [JW-1:0] raw [NUM_PLAYERS];
    logic          pause_raw;

    // Key OR joystick per player; pause merged across all players.
    always_comb begin
        pause_raw = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            raw[p]    = key_q[p] | joystick[p*JW +: JW];
            pause_raw = pause_raw | raw[p][PAUSE_B];
        end
    end

    // ------------------------------------------------------------------
    // Coin pulse shaping
    // ------------------------------------------------------------------
    logic [CW-1:0]          coin_cnt     [NUM_PLAYERS];
    logic [CW-1:0]          coin_cnt_nxt [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] coin_prev;

    // Load on a rising edge only when idle, otherwise count down to zero.
    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            coin_cnt_nxt[p] = coin_cnt[p];
            if (coin_cnt[p] != '0) begin
                coin_cnt_nxt[p] = coin_cnt[p] - CW'(1);
            end else if (raw[p][COIN_B] && !coin_prev[p]) begin
                coin_cnt_nxt[p] = CW'(COIN_PULSE);
            end
        end
    end

    // Coin counters; edge history follows the raw level even in reset so a
    // coin held through reset does not fire again on release.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            coin_prev[p] <= raw[p][COIN_B];
            coin_cnt[p]  <= reset ? '0 : coin_cnt_nxt[p];
        end
    end

    // ------------------------------------------------------------------
    // Autofire timebase
    // ------------------------------------------------------------------
    logic [AW-1:0] af_cnt;
    logic          af_phase;

    // Free-running half-period counter; phase flips on each wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            af_cnt   <= '0;
            af_phase <= 1'b1;
        end else if (af_cnt == AW'(AUTOFIRE_HALF - 1)) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt   <= af_cnt + AW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output word assembly
    // ------------------------------------------------------------------
    logic [NUM_PLAYERS*OW-1:0] player_nxt;

    // Reorder directions, gate autofire buttons, insert shaped coin.
    always_comb begin
        player_nxt = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            player_nxt[p*OW + 0] = raw[p][3];
            player_nxt[p*OW + 1] = raw[p][2];
            player_nxt[p*OW + 2] = raw[p][1];
            player_nxt[p*OW + 3] = raw[p][0];
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                player_nxt[p*OW + 4 + i] = raw[p][4+i] & (~autofire_en[i] | af_phase);
            end
            player_nxt[p*OW + START_B] = raw[p][START_B];
            player_nxt[p*OW + COIN_B]  = (coin_cnt_nxt[p] != '0);
        end
    end

    // Registered player outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            player <= '0;
        end else begin
            player <= player_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Pause
    // ------------------------------------------------------------------
    if (PAUSE_TOGGLE != 0) begin : g_pause_toggle
        logic pause_prev;

        // Latch flips on each rising edge of the merged pause level.
        always_ff @(posedge clock) begin
            pause_prev <= pause_raw;
            if (reset) begin
                pause <= 1'b0;
            end else if (pause_raw && !pause_prev) begin
                pause <= ~pause;
            end
        end
    end else begin : g_pause_level
        // Pause simply follows the merged level, one cycle late.
        always_ff @(posedge clock) begin
            if (reset) begin
                pause <= 1'b0;
            end else begin
                pause <= pause_raw;
            end
        end
    end

endmodule
